copper_mem_ctl: RTL and testbench

COPPER_MEM_CTL -- requirements
Module: copper_mem_ctl

---
 rtl/xosera_pkg.sv | 18 +
 rtl/copper_spram.sv | 25 ++
 rtl/copper_mem_ctl.sv | 123 ++++++++++++
 tb/tb_copper_mem_ctl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xosera_pkg.sv
// Shared definitions for the copper memory controller: host FSM states,
// starve counter width and the even-parity helper.
package xosera_pkg;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_WAIT = 2'd1,
        H_ACK  = 2'd2
    } host_state_e;

    localparam int STARVE_W = 8;

    // Even parity over a zero-extended word: returns the bit that makes the total XOR zero.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/copper_spram.sv
// Single-port inferred RAM, one access per clock, registered read-first output.
module copper_spram #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/copper_mem_ctl.sv
// Copper/host arbiter over one single-port RAM with starvation guard for the host.
// Optional word parity and sticky error flag when COPPER_MEM_PARITY_EN is defined.
module copper_mem_ctl
    import xosera_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic              cop_rd_en_i,
    input  logic [ADDR_W-1:0] cop_rd_addr_i,
    output logic              cop_busy_o,
    output logic              cop_rd_valid_o,
    output logic [DATA_W-1:0] cop_rd_data_o,
    input  logic              host_req_i,
    input  logic              host_wr_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [DATA_W-1:0] host_data_i,
    output logic              host_ack_o,
    output logic [DATA_W-1:0] host_data_o
`ifdef COPPER_MEM_PARITY_EN
    ,
    output logic              cop_par_err_o
`endif
);

`ifdef COPPER_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    host_state_e         state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                cop_vld_q;
    logic [DATA_W-1:0]   cop_hold_q;
    logic                host_grant, cop_grant, ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [MEM_W-1:0]    ram_wdata, ram_rdata;
    logic [DATA_W-1:0]   ram_word;

    // Copper owns the RAM by default; a waiting host breaks in when idle or starved.
    assign host_grant = (state_q == H_WAIT) && (!cop_rd_en_i || (starve_q == STARVE_LIM));
    assign cop_grant  = cop_rd_en_i && !host_grant;
    assign cop_busy_o = cop_rd_en_i && host_grant;
    assign ram_we     = host_grant && host_wr_i;
    assign ram_addr   = host_grant ? host_addr_i : cop_rd_addr_i;
`ifdef COPPER_MEM_PARITY_EN
    assign ram_wdata  = {even_parity(64'(host_data_i)), host_data_i};
`else
    assign ram_wdata  = host_data_i;
`endif
    assign ram_word   = ram_rdata[DATA_W-1:0];

    copper_spram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (MEM_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            H_IDLE: begin
                if (host_req_i) state_d = H_WAIT;
            end
            H_WAIT: begin
                if (host_grant) begin
                    state_d  = H_ACK;
                    starve_d = '0;
                end else begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            H_ACK:   state_d = H_IDLE;
            default: state_d = H_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= H_IDLE;
            starve_q   <= '0;
            cop_vld_q  <= 1'b0;
            cop_hold_q <= '0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            cop_vld_q <= cop_grant;
            if (cop_vld_q) cop_hold_q <= ram_word;
        end
    end

    // RAM output is not resettable, so outputs are gated by the reset-cleared control flops.
    assign cop_rd_valid_o = cop_vld_q;
    assign cop_rd_data_o  = cop_vld_q ? ram_word : cop_hold_q;
    assign host_ack_o     = (state_q == H_ACK);
    assign host_data_o    = host_ack_o ? ram_word : '0;

`ifdef COPPER_MEM_PARITY_EN
    logic par_err_q;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            par_err_q <= 1'b0;
        end else if (cop_vld_q && (^ram_rdata)) begin
            par_err_q <= 1'b1;
        end
    end

    assign cop_par_err_o = par_err_q;
`endif

endmodule

// File: tb/tb_copper_mem_ctl.sv
// Bench for copper_mem_ctl: directed scenarios plus randomized traffic against a reference model.
`timescale 1ns/1ps
module tb_copper_mem_ctl;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n = 1'b0;
    logic              cop_en, cop_busy, cop_valid;
    logic [ADDR_W-1:0] cop_addr;
    logic [DATA_W-1:0] cop_data;
    logic              h_req, h_wr, h_ack;
    logic [ADDR_W-1:0] h_addr;
    logic [DATA_W-1:0] h_wdata, h_rdata;

    logic              s_cop_en, s_busy, s_valid, s_req, s_wr, s_ack;
    logic [3:0]        s_cop_addr, s_addr;
    logic [DATA_W-1:0] s_cdata, s_wdata, s_hdata;
`ifdef COPPER_MEM_PARITY_EN
    logic par_err, s_par_err;
`endif

    int checks   = 0;
    int failures = 0;

    copper_mem_ctl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clk(clk), .reset_n_i(reset_n),
        .cop_rd_en_i(cop_en), .cop_rd_addr_i(cop_addr), .cop_busy_o(cop_busy),
        .cop_rd_valid_o(cop_valid), .cop_rd_data_o(cop_data),
        .host_req_i(h_req), .host_wr_i(h_wr), .host_addr_i(h_addr), .host_data_i(h_wdata),
        .host_ack_o(h_ack), .host_data_o(h_rdata)
`ifdef COPPER_MEM_PARITY_EN
        , .cop_par_err_o(par_err)
`endif
    );

    copper_mem_ctl #(.ADDR_W(4), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) u_dut4 (
        .clk(clk), .reset_n_i(reset_n),
        .cop_rd_en_i(s_cop_en), .cop_rd_addr_i(s_cop_addr), .cop_busy_o(s_busy),
        .cop_rd_valid_o(s_valid), .cop_rd_data_o(s_cdata),
        .host_req_i(s_req), .host_wr_i(s_wr), .host_addr_i(s_addr), .host_data_i(s_wdata),
        .host_ack_o(s_ack), .host_data_o(s_hdata)
`ifdef COPPER_MEM_PARITY_EN
        , .cop_par_err_o(s_par_err)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        cop_en = 1'b0; cop_addr = '0; h_req = 1'b0; h_wr = 1'b0; h_addr = '0; h_wdata = '0;
        s_cop_en = 1'b0; s_cop_addr = '0; s_req = 1'b0; s_wr = 1'b0; s_addr = '0; s_wdata = '0;
    endtask

    function automatic logic [ADDR_W-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 10'h010 : 10'(10'h040 + r);
    endfunction

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        mid();
        checks++; if (cop_valid !== 1'b0) begin failures++; $display("FAIL reset_cop_valid got=%b want=0", cop_valid); end
        checks++; if (cop_data !== 16'h0) begin failures++; $display("FAIL reset_cop_data got=%h want=0000", cop_data); end
        checks++; if (h_ack !== 1'b0) begin failures++; $display("FAIL reset_host_ack got=%b want=0", h_ack); end
        checks++; if (h_rdata !== 16'h0) begin failures++; $display("FAIL reset_host_data got=%h want=0000", h_rdata); end
        checks++; if (cop_busy !== 1'b0) begin failures++; $display("FAIL reset_cop_busy got=%b want=0", cop_busy); end
        checks++; if (s_valid !== 1'b0) begin failures++; $display("FAIL reset_s_valid got=%b want=0", s_valid); end
`ifdef COPPER_MEM_PARITY_EN
        checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL reset_par_err got=%b want=0", par_err); end
`endif
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        h_req = 1'b1; h_wr = 1'b1; h_addr = 10'h010; h_wdata = 16'hB000; cop_en = 1'b0;
        mid();
        checks++; if (h_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_early got=%b want=0", h_ack); end
        tick();
        mid();
        checks++; if (h_ack !== 1'b0) begin failures++; $display("FAIL wr_ack_grant_cycle got=%b want=0", h_ack); end
        tick();
        cop_en = 1'b1; cop_addr = 10'h010;
        mid();
        checks++; if (h_ack !== 1'b1) begin failures++; $display("FAIL wr_ack got=%b want=1", h_ack); end
        checks++; if (cop_busy !== 1'b0) begin failures++; $display("FAIL wr_cop_busy got=%b want=0", cop_busy); end
        tick();
        h_req = 1'b0; cop_en = 1'b0;
        mid();
        checks++; if (cop_valid !== 1'b1) begin failures++; $display("FAIL rd_after_wr_valid got=%b want=1", cop_valid); end
        checks++; if (cop_data !== 16'hB000) begin failures++; $display("FAIL rd_after_wr_data got=%h want=b000", cop_data); end
        tick();
        mid();
        checks++; if (cop_valid !== 1'b0) begin failures++; $display("FAIL hold_valid got=%b want=0", cop_valid); end
        checks++; if (cop_data !== 16'hB000) begin failures++; $display("FAIL hold_data got=%h want=b000", cop_data); end
        tick();
    endtask

    task automatic test_starve();
        int busy_at;
        busy_at = 0;
        h_req = 1'b1; h_wr = 1'b0; h_addr = 10'h010; cop_en = 1'b1; cop_addr = 10'h010;
        mid();
        checks++; if (cop_busy !== 1'b0) begin failures++; $display("FAIL starve_first_busy got=%b want=0", cop_busy); end
        tick();
        for (int i = 1; i <= 10; i++) begin
            mid();
            if (cop_busy === 1'b1) begin
                busy_at = i;
                break;
            end
            tick();
        end
        checks++; if (busy_at != STARVE_MAX + 1) begin failures++; $display("FAIL starve_grant_cycle got=%0d want=%0d", busy_at, STARVE_MAX + 1); end
        if (busy_at != 0) begin
            tick();
            mid();
            checks++; if (h_ack !== 1'b1) begin failures++; $display("FAIL starve_ack got=%b want=1", h_ack); end
            checks++; if (h_rdata !== 16'hB000) begin failures++; $display("FAIL starve_host_data got=%h want=b000", h_rdata); end
            checks++; if (cop_busy !== 1'b0) begin failures++; $display("FAIL starve_busy_after got=%b want=0", cop_busy); end
            checks++; if (cop_valid !== 1'b0) begin failures++; $display("FAIL starve_denied_valid got=%b want=0", cop_valid); end
            tick();
            h_req = 1'b0;
            mid();
            checks++; if (h_ack !== 1'b0) begin failures++; $display("FAIL starve_ack_one_cycle got=%b want=0", h_ack); end
            checks++; if (cop_valid !== 1'b1) begin failures++; $display("FAIL starve_cop_resume got=%b want=1", cop_valid); end
        end
        tick();
        h_req = 1'b0; cop_en = 1'b0;
        tick();
    endtask

    task automatic test_same_cycle();
        h_req = 1'b1; h_wr = 1'b0; h_addr = 10'h010; cop_en = 1'b1; cop_addr = 10'h010;
        mid();
        checks++; if (cop_busy !== 1'b0) begin failures++; $display("FAIL same_busy0 got=%b want=0", cop_busy); end
        tick();
        mid();
        checks++; if (cop_busy !== 1'b0) begin failures++; $display("FAIL same_busy1 got=%b want=0", cop_busy); end
        checks++; if (cop_data !== 16'hB000 || cop_valid !== 1'b1) begin failures++; $display("FAIL same_cop_rd got=%b/%h want=1/b000", cop_valid, cop_data); end
        tick();
        cop_en = 1'b0;
        mid();
        checks++; if (h_ack !== 1'b0) begin failures++; $display("FAIL same_ack_early got=%b want=0", h_ack); end
        tick();
        mid();
        checks++; if (h_ack !== 1'b1) begin failures++; $display("FAIL same_ack got=%b want=1", h_ack); end
        checks++; if (h_rdata !== 16'hB000) begin failures++; $display("FAIL same_host_data got=%h want=b000", h_rdata); end
        tick();
        h_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        int acks;
        acks = 0;
        h_req = 1'b1; h_wr = 1'b0; h_addr = 10'h010; cop_en = 1'b1; cop_addr = 10'h020;
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        checks++; if (cop_valid !== 1'b0) begin failures++; $display("FAIL rstw_cop_valid got=%b want=0", cop_valid); end
        checks++; if (cop_data !== 16'h0) begin failures++; $display("FAIL rstw_cop_data got=%h want=0000", cop_data); end
        checks++; if (h_ack !== 1'b0 || h_rdata !== 16'h0) begin failures++; $display("FAIL rstw_host got=%b/%h want=0/0000", h_ack, h_rdata); end
        checks++; if (cop_busy !== 1'b0) begin failures++; $display("FAIL rstw_busy got=%b want=0", cop_busy); end
        h_req = 1'b0; cop_en = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        cop_en = 1'b1; cop_addr = 10'h010;
        mid();
        if (h_ack === 1'b1) acks++;
        tick();
        cop_en = 1'b0;
        mid();
        checks++; if (cop_valid !== 1'b1) begin failures++; $display("FAIL rstw_first_edge_valid got=%b want=1", cop_valid); end
        checks++; if (cop_data !== 16'hB000) begin failures++; $display("FAIL rstw_mem_kept got=%h want=b000", cop_data); end
        repeat (4) begin
            tick();
            mid();
            if (h_ack === 1'b1) acks++;
        end
        checks++; if (acks != 0) begin failures++; $display("FAIL rstw_dropped_ack got=%0d want=0", acks); end
        tick();
    endtask

    task automatic test_addr_wrap();
        logic [7:0] wide;
        wide = 8'h13;
        s_req = 1'b1; s_wr = 1'b1; s_addr = wide[3:0]; s_wdata = 16'h5A13; s_cop_en = 1'b0;
        tick();
        tick();
        mid();
        checks++; if (s_ack !== 1'b1) begin failures++; $display("FAIL wrap_ack got=%b want=1", s_ack); end
        tick();
        s_req = 1'b0; s_cop_en = 1'b1; s_cop_addr = 4'h3;
        tick();
        s_cop_en = 1'b0;
        mid();
        checks++; if (s_valid !== 1'b1 || s_cdata !== 16'h5A13) begin failures++; $display("FAIL wrap_word3 got=%b/%h want=1/5a13", s_valid, s_cdata); end
        tick();
    endtask

`ifdef COPPER_MEM_PARITY_EN
    task automatic test_parity();
        h_req = 1'b1; h_wr = 1'b1; h_addr = 10'h020; h_wdata = 16'h1234;
        tick();
        tick();
        tick();
        h_req = 1'b0;
        u_dut.u_ram.mem_q[32] = u_dut.u_ram.mem_q[32] ^ 17'h00001;
        mid();
        checks++; if (par_err !== 1'b0) begin failures++; $display("FAIL par_before got=%b want=0", par_err); end
        tick();
        cop_en = 1'b1; cop_addr = 10'h020;
        tick();
        cop_en = 1'b0;
        tick();
        mid();
        checks++; if (par_err !== 1'b1) begin failures++; $display("FAIL par_set got=%b want=1", par_err); end
        repeat (3) tick();
        mid();
        checks++; if (par_err !== 1'b1) begin failures++; $display("FAIL par_sticky got=%b want=1", par_err); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [DATA_W-1:0] ref_mem [int];
        logic [DATA_W-1:0] exp_cdata, exp_hdata, last_cop;
        bit eligible, ack_now, was_ack, grant, copwin, exp_valid, cdata_known, hdata_known, last_known, h_done;
        int starve;
        eligible = 0; ack_now = 0; exp_valid = 0; cdata_known = 0; hdata_known = 0;
        last_known = 0; h_done = 0; starve = 0;
        exp_cdata = '0; exp_hdata = '0; last_cop = '0;
        ref_mem[32'h010] = 16'hB000;
        idle_inputs();
        for (int cyc = 0; cyc < 400; cyc++) begin
            cop_en   = ($urandom_range(0, 2) != 0);
            cop_addr = pick_addr();
            if (!h_req || h_done) begin
                if ($urandom_range(0, 2) == 0) begin
                    h_req = 1'b1; h_wr = $urandom_range(0, 1) == 1;
                    h_addr = pick_addr(); h_wdata = 16'($urandom);
                end else begin
                    h_req = 1'b0;
                end
            end
            mid();
            // Host is served once it has waited a cycle and the copper is idle or has won STARVE_MAX times.
            grant  = eligible && (!cop_en || starve == STARVE_MAX);
            copwin = cop_en && !grant;
            checks++; if (cop_busy !== (cop_en && grant)) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", cyc, cop_busy, cop_en && grant); end
            checks++; if (cop_valid !== exp_valid) begin failures++; $display("FAIL rnd_cop_valid cyc=%0d got=%b want=%b", cyc, cop_valid, exp_valid); end
            if (exp_valid && cdata_known) begin
                checks++; if (cop_data !== exp_cdata) begin failures++; $display("FAIL rnd_cop_data cyc=%0d got=%h want=%h", cyc, cop_data, exp_cdata); end
            end else if (!exp_valid && last_known) begin
                checks++; if (cop_data !== last_cop) begin failures++; $display("FAIL rnd_cop_hold cyc=%0d got=%h want=%h", cyc, cop_data, last_cop); end
            end
            checks++; if (h_ack !== ack_now) begin failures++; $display("FAIL rnd_host_ack cyc=%0d got=%b want=%b", cyc, h_ack, ack_now); end
            if (ack_now && hdata_known) begin
                checks++; if (h_rdata !== exp_hdata) begin failures++; $display("FAIL rnd_host_data cyc=%0d got=%h want=%h", cyc, h_rdata, exp_hdata); end
            end
            if (exp_valid) begin
                last_cop = exp_cdata; last_known = cdata_known;
            end
            exp_valid   = copwin;
            cdata_known = copwin && ref_mem.exists(int'(cop_addr));
            if (cdata_known) exp_cdata = ref_mem[int'(cop_addr)];
            was_ack     = ack_now;
            ack_now     = grant;
            hdata_known = 0;
            if (grant) begin
                if (h_wr) begin
                    ref_mem[int'(h_addr)] = h_wdata;
                end else if (ref_mem.exists(int'(h_addr))) begin
                    exp_hdata = ref_mem[int'(h_addr)]; hdata_known = 1;
                end
                eligible = 0; starve = 0;
            end else if (eligible) begin
                starve++;
            end else if (!was_ack && h_req) begin
                eligible = 1;
            end
            h_done = was_ack;
            tick();
        end
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        test_reset();
        test_write_read();
        test_starve();
        test_same_cycle();
        test_reset_mid_wait();
        test_addr_wrap();
`ifdef COPPER_MEM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
